apb_master: RTL
===============

Name: apb_master

Overview:
- APB initiator for the peripheral subsystem; drives the shared APB bus (pAdd, pwData, pwr, psel, pen) and samples prdata/pready from the GPIO and UART slaves.
- Converts single-beat commands from a local controller (cmd valid/ready) into APB SETUP/ACCESS transfers.
- Returns read data and a status response per command.
- Aborts any transfer whose slave never asserts pready within a bounded wait.

Parameters:
- ADDR_W, 32, width of pAdd and cmd_addr.
- DATA_W, 32, width of pwData, prdata, cmd_wdata, rsp_rdata.
- NUM_SLAVES, 2, width of psel / cmd_sel; bit 0 = GPIO, bit 1 = UART.
- TIMEOUT, 16, maximum ACCESS cycles with pready low before the transfer is aborted; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_sel  in  NUM_SLAVES  one-hot target slave.
- cmd_addr  in  ADDR_W  register address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_err  out  1  qualifies rsp_valid; 1 = bad select or timeout.
- rsp_rdata  out  DATA_W  read data; qualified by rsp_valid, read, and !rsp_err.
- pAdd  out  ADDR_W  APB address.
- pwData  out  DATA_W  APB write data.
- pwr  out  1  APB write enable.
- psel  out  NUM_SLAVES  APB one-hot slave select.
- pen  out  1  APB enable (ACCESS phase).
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB slave ready.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state = IDLE, cmd_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, pAdd = 0, pwData = 0, pwr = 0, psel = 0, pen = 0, wait counter = 0.
- All outputs are registered. States: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready = 1; psel = 0, pen = 0.
  - On cmd_valid and a valid cmd_sel (exactly one bit set): latch cmd_addr, cmd_wdata, cmd_write and cmd_sel into pAdd, pwData, pwr and psel; go to SETUP.
  - On cmd_valid with cmd_sel zero or multi-hot: no bus activity; next cycle rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; stay in IDLE.
- SETUP: cmd_ready = 0, psel asserted, pen = 0; lasts exactly one cycle; go to ACCESS with pen = 1.
- ACCESS:
  - psel and pen stay asserted; pAdd, pwData and pwr stay stable.
  - On pready = 1: go to IDLE with psel = 0 and pen = 0. In the same edge, rsp_valid = 1 and rsp_err = 0. For a read, rsp_rdata = prdata sampled at that edge; for a write, rsp_rdata = 0.
  - On pready = 0: increment the wait counter. If the counter reaches TIMEOUT, abort: go to IDLE with psel = 0 and pen = 0, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - The wait counter clears on entry to SETUP.
- Latency:
  - Zero-wait transfer: accept at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid high in cycle N+3.
  - Each pready-low cycle adds 1.
  - Minimum command spacing is 3 cycles; a new command can be accepted in the same cycle rsp_valid is high.
- In IDLE, pAdd, pwData and pwr hold their last values; only psel and pen return to 0.
- rsp_valid is a single-cycle pulse. There is no response backpressure.
- prdata is ignored except in an ACCESS cycle with pready high on a read.
- If pready is high in the last allowed wait cycle, completion wins over timeout.
- Reset mid-operation: the transfer is dropped at the next edge, outputs return to reset values, and no response is issued.
- cmd_valid while cmd_ready = 0 is ignored; the command is not queued.

Test Plan:
1. Reset, then write: cmd_sel = 2'b10, addr = 15, wdata = "ABCD" (0x41424344), pready tied high. Required: psel = 2'b10 with pen = 0 for 1 cycle, then pen = 1 for 1 cycle, pwr = 1, pAdd = 15, pwData = 0x41424344; rsp_valid 3 cycles after accept, rsp_err = 0.
2. Read from GPIO: cmd_sel = 2'b01, addr = 4; slave holds pready low 3 cycles, then drives prdata = 0x000000A5 with pready high. Required: pen high for 4 cycles, rsp_rdata = 0xA5, rsp_err = 0, total latency 6 cycles.
3. Timeout: pready stuck low, TIMEOUT = 16. Required: pen high for exactly 16 cycles, then psel = 0, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
4. Bad select: cmd_sel = 2'b11, then cmd_sel = 2'b00. Required: psel never asserts; rsp_err = 1 one cycle after each accept; cmd_ready stays 1.
5. Back-to-back: cmd_valid held high with 4 writes queued. Required: one accept every 3 cycles, no gap cycles, pAdd stable during each SETUP/ACCESS.
6. rst pulsed during ACCESS of a read. Required: psel, pen and rsp_valid all 0 at the next edge; no response pulse; the next command completes normally.

Source files
------------

// File: rtl/apb_master.sv
// APB initiator: turns single-beat local commands into SETUP/ACCESS transfers
// and returns one registered response per command, with a bounded pready wait.
module apb_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [NUM_SLAVES-1:0] cmd_sel,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [ADDR_W-1:0]     pAdd,
  output logic [DATA_W-1:0]     pwData,
  output logic                  pwr,
  output logic [NUM_SLAVES-1:0] psel,
  output logic                  pen,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0]     pAdd_q, pAdd_d;
  logic [DATA_W-1:0]     pwData_q, pwData_d;
  logic                  pwr_q, pwr_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  pen_q, pen_d;
  logic                  sel_ok;

  // exactly one slave selected
  assign sel_ok = (cmd_sel != '0) &&
                  ((cmd_sel & (cmd_sel - NUM_SLAVES'(1))) == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    pAdd_d      = pAdd_q;
    pwData_d    = pwData_q;
    pwr_d       = pwr_q;
    psel_d      = psel_q;
    pen_d       = pen_q;
    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        psel_d      = '0;
        pen_d       = 1'b0;
        if (cmd_valid) begin
          if (sel_ok) begin
            pAdd_d      = cmd_addr;
            pwData_d    = cmd_wdata;
            pwr_d       = cmd_write;
            psel_d      = cmd_sel;
            cmd_ready_d = 1'b0;
            cnt_d       = '0;
            state_d     = SETUP;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      SETUP: begin
        pen_d   = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        // completion is checked first so it wins on the last wait cycle
        if (pready) begin
          state_d     = IDLE;
          psel_d      = '0;
          pen_d       = 1'b0;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwr_q ? '0 : prdata;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == TMO) begin
            state_d     = IDLE;
            psel_d      = '0;
            pen_d       = 1'b0;
            cmd_ready_d = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      pAdd_q      <= '0;
      pwData_q    <= '0;
      pwr_q       <= 1'b0;
      psel_q      <= '0;
      pen_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      pAdd_q      <= pAdd_d;
      pwData_q    <= pwData_d;
      pwr_q       <= pwr_d;
      psel_q      <= psel_d;
      pen_q       <= pen_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign pAdd      = pAdd_q;
  assign pwData    = pwData_q;
  assign pwr       = pwr_q;
  assign psel      = psel_q;
  assign pen       = pen_q;

endmodule
